// File: rtl/fog_ma_pkg.sv
// Shared constants and helpers for the FOG boxcar averager.
// The rounding mode is chosen by the FOG_MA_ROUND_EN macro in fog_moving_average_mc.
package fog_ma_pkg;

    localparam int unsigned FOG_MA_DIN_W    = 14;
    localparam int unsigned FOG_MA_MAX_LOG2 = 6;
    localparam int unsigned SUM_W           = FOG_MA_DIN_W + FOG_MA_MAX_LOG2;
    localparam int unsigned DEPTH           = 2 ** FOG_MA_MAX_LOG2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Window exponents above the buffer capacity saturate at the largest window.
    function automatic int unsigned clamp_k(input int unsigned sel,
                                           input int unsigned max_k = FOG_MA_MAX_LOG2);
        return (sel > max_k) ? max_k : sel;
    endfunction

endpackage

// File: rtl/fog_ma_ring.sv
// Circular sample buffer for the boxcar averager. It has a synchronous write port
// and an asynchronous read port, so the oldest sample is available in the same cycle.
module fog_ma_ring
    import fog_ma_pkg::*;
#(
    parameter int unsigned DIN_W    = FOG_MA_DIN_W,
    parameter int unsigned MAX_LOG2 = FOG_MA_MAX_LOG2
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [MAX_LOG2-1:0] i_wp,
    input  logic [DIN_W-1:0]    i_din,
    input  logic [MAX_LOG2-1:0] i_rd_addr,
    output logic [DIN_W-1:0]    o_rd_data
);

    logic [DIN_W-1:0] mem_q [2**MAX_LOG2];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_wp] <= i_din;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/fog_moving_average_mc.sv
// Runtime-configurable power-of-two boxcar averager for FOG demodulated samples.
// Defining FOG_MA_ROUND_EN selects round-half-up; otherwise the average is floored.
module fog_moving_average_mc
    import fog_ma_pkg::*;
#(
    parameter  int unsigned DIN_W    = FOG_MA_DIN_W,
    parameter  int unsigned MAX_LOG2 = FOG_MA_MAX_LOG2,
    localparam int unsigned KW       = clog2(MAX_LOG2 + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din_valid,
    input  logic [DIN_W-1:0] i_din,
    input  logic [KW-1:0]    i_win_sel,
    input  logic             i_clear,
    output logic             o_dout_valid,
    output logic [DIN_W-1:0] o_dout,
    output logic             o_full
);

    localparam int unsigned ACC_W = DIN_W + MAX_LOG2;
    localparam int unsigned FW    = MAX_LOG2 + 1;

    logic [MAX_LOG2-1:0]     wp_q, wp_d, rd_addr;
    logic [FW-1:0]           fill_q, fill_d, n_win;
    logic signed [ACC_W-1:0] sum_q, sum_d, din_ext, old_ext, acc_r;
    logic [KW-1:0]           k_q, k_sel;
    logic                    init_q;
    logic                    flush, accept, win_full, full_d;
    logic [DIN_W-1:0]        old_sample, avg;
    logic                    dout_valid_q, full_q;
    logic [DIN_W-1:0]        dout_q;

    fog_ma_ring #(
        .DIN_W    (DIN_W),
        .MAX_LOG2 (MAX_LOG2)
    ) u_ring (
        .i_clk     (i_clk),
        .i_we      (accept),
        .i_wp      (wp_q),
        .i_din     (i_din),
        .i_rd_addr (rd_addr),
        .o_rd_data (old_sample)
    );

    always_comb begin
        k_sel    = KW'(clamp_k(32'(i_win_sel), MAX_LOG2));
        // The first edge after reset only latches the exponent; it must not flush.
        flush    = i_clear || (init_q && (k_sel != k_q));
        accept   = i_din_valid && !flush;
        n_win    = FW'(1) << k_sel;
        rd_addr  = wp_q - MAX_LOG2'(n_win);
        win_full = (fill_q == n_win);
        din_ext  = {{MAX_LOG2{i_din[DIN_W-1]}}, i_din};
        old_ext  = win_full ? {{MAX_LOG2{old_sample[DIN_W-1]}}, old_sample} : '0;
        sum_d    = sum_q + din_ext - old_ext;
        fill_d   = win_full ? fill_q : fill_q + FW'(1);
        full_d   = (fill_d == n_win);
        wp_d     = wp_q + MAX_LOG2'(1);
        acc_r    = sum_d;
`ifdef FOG_MA_ROUND_EN
        if (k_sel != '0) begin
            acc_r = sum_d + (ACC_W'(1) << (k_sel - KW'(1)));
        end
`endif
        avg      = DIN_W'(acc_r >>> k_sel);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wp_q         <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            k_q          <= '0;
            init_q       <= 1'b0;
            full_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            init_q       <= 1'b1;
            k_q          <= k_sel;
            dout_valid_q <= 1'b0;
            if (flush) begin
                wp_q   <= '0;
                fill_q <= '0;
                sum_q  <= '0;
                full_q <= 1'b0;
            end else if (accept) begin
                wp_q   <= wp_d;
                fill_q <= fill_d;
                sum_q  <= sum_d;
                full_q <= full_d;
                if (full_d) begin
                    dout_q       <= avg;
                    dout_valid_q <= 1'b1;
                end
            end
        end
    end

    assign o_dout       = dout_q;
    assign o_dout_valid = dout_valid_q;
    assign o_full       = full_q;

endmodule

// File: tb/tb_fog_moving_average_mc.sv
// Self-checking bench for fog_moving_average_mc: directed vector table, hand-written
// corner sequences and randomized traffic checked against a sliding-window model.
module tb_fog_moving_average_mc;

    localparam int DW = 14;
    localparam int ML = 6;
`ifdef FOG_MA_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 din_valid;
    logic [DW-1:0]        din;
    logic [2:0]           win_sel;
    logic                 clear;
    logic                 dout_valid;
    logic signed [DW-1:0] dout;
    logic                 full;

    int n_cmp = 0;
    int n_err = 0;

    fog_moving_average_mc #(
        .DIN_W    (DW),
        .MAX_LOG2 (ML)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_din_valid  (din_valid),
        .i_din        (din),
        .i_win_sel    (win_sel),
        .i_clear      (clear),
        .o_dout_valid (dout_valid),
        .o_dout       (dout),
        .o_full       (full)
    );

    always #5 clk = ~clk;

    // Reference model: the window is simply the last N accepted samples.
    int win_q[$];
    int mk;
    bit minit;
    bit ev;
    int ed;
    bit ef;

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_avg();
        int s;
        int n;
        s = 0;
        n = win_q.size();
        foreach (win_q[i]) s += win_q[i];
        if (RND) s += n / 2;
        return floor_div(s, n);
    endfunction

    function automatic void model_reset();
        win_q.delete();
        minit = 1'b0;
        mk    = 0;
        ev    = 1'b0;
        ed    = 0;
        ef    = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input int d, input int s, input bit c);
        int ks;
        bit fl;
        ks    = (s > ML) ? ML : s;
        fl    = c || (minit && (ks != mk));
        mk    = ks;
        minit = 1'b1;
        ev    = 1'b0;
        if (fl) begin
            win_q.delete();
            ef = 1'b0;
        end else if (v) begin
            win_q.push_back(d);
            if (win_q.size() > (1 << ks)) void'(win_q.pop_front());
            if (win_q.size() == (1 << ks)) begin
                ef = 1'b1;
                ev = 1'b1;
                ed = ref_avg();
            end else begin
                ef = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input int d, input int s, input bit c);
        din_valid = v;
        din       = DW'(d);
        win_sel   = 3'(s);
        clear     = c;
        @(posedge clk);
        model_step(v, d, s, c);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, int'(dout_valid), int'(ev));
        chk({tag, "_full"},  int'(full),       int'(ef));
        chk({tag, "_dout"},  dout,             ed);
    endtask

    typedef struct {
        bit v;
        int d;
        int s;
        bit c;
        bit ev;
        int ed;
        bit ef;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input bit v, input int d, input int s, input bit c,
                                    input bit xv, input int xd, input bit xf);
        vec_t r;
        r.v = v; r.d = d; r.s = s; r.c = c; r.ev = xv; r.ed = xd; r.ef = xf;
        tbl.push_back(r);
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s_cur;
        bit v;
        int d;

        // Fill and steady state: k=3, eight samples of 100.
        for (int i = 0; i < 8; i++) add_vec(1, 100, 3, 0, i == 7, 100, i == 7);
        // Ramp at k=2; the window change cycle itself is a flush.
        add_vec(0, 0, 2, 0, 0, 0, 0);
        add_vec(1, 1, 2, 0, 0, 0, 0);
        add_vec(1, 2, 2, 0, 0, 0, 0);
        add_vec(1, 3, 2, 0, 0, 0, 0);
        add_vec(1, 4, 2, 0, 1, RND ? 3 : 2, 1);
        add_vec(1, 5, 2, 0, 1, RND ? 4 : 3, 1);
        // Negative values at k=1.
        add_vec(0, 0, 1, 0, 0, 0, 0);
        add_vec(1, -3, 1, 0, 0, 0, 0);
        add_vec(1, -4, 1, 0, 1, RND ? -3 : -4, 1);
        // Window change 3 -> 2 with a valid sample in the change cycle.
        add_vec(0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(1, 50, 3, 0, i == 7, 50, i == 7);
        add_vec(1, 999, 2, 0, 0, 0, 0);
        add_vec(1, 10, 2, 0, 0, 0, 0);
        add_vec(1, 20, 2, 0, 0, 0, 0);
        add_vec(1, 30, 2, 0, 0, 0, 0);
        add_vec(1, 40, 2, 0, 1, 25, 1);
        // Clear together with a valid sample.
        add_vec(1, 500, 2, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(1, 8, 2, 0, i == 3, 8, i == 3);
        add_vec(0, 0, 2, 0, 0, 0, 1);

        rst = 1'b1; din_valid = 1'b0; din = '0; win_sel = 3'd3; clear = 1'b0;
        model_reset();
        #1;
        chk("reset_dout",  dout,             0);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_full",  int'(full),       0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].c);
            chk($sformatf("tbl%0d_valid", i), int'(dout_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_full", i),  int'(full),       int'(tbl[i].ef));
            if (tbl[i].ev) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
        end

        // Extremes at the largest window, then an over-range selector that clamps.
        step(0, 0, 6, 0);
        for (int i = 0; i < 64; i++) begin
            step(1, -8192, 6, 0);
            check_model("ext_neg");
        end
        chk("ext_neg_final", dout, -8192);
        chk("ext_neg_valid", int'(dout_valid), 1);
        for (int i = 0; i < 64; i++) begin
            step(1, 8191, 6, 0);
            check_model("ext_pos");
        end
        chk("ext_pos_final", dout, 8191);
        step(1, 8191, 7, 0);
        chk("clamp_valid", int'(dout_valid), 1);
        chk("clamp_full",  int'(full),       1);
        chk("clamp_dout",  dout,             8191);

        // Gapped valid at k=2.
        step(0, 0, 2, 0);
        for (int i = 0; i < 36; i++) begin
            step(i % 3 == 2, int'($urandom_range(0, 16383)) - 8192, 2, 0);
            check_model("gap");
        end

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dout",  dout,             0);
        chk("arst_valid", int'(dout_valid), 0);
        chk("arst_full",  int'(full),       0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1, 100 + 4 * i, 2, 0);
            check_model("post_rst");
            chk($sformatf("post_rst_pulse%0d", i), int'(dout_valid), (i == 3) ? 1 : 0);
        end
        chk("post_rst_dout", dout, RND ? 106 : 106);

        // Randomized traffic against the model.
        s_cur = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) s_cur = int'($urandom_range(0, 7));
            v = ($urandom_range(0, 9) < 7);
            d = int'($urandom_range(0, 16383)) - 8192;
            step(v, d, s_cur, $urandom_range(0, 199) == 0);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
